nibble_alu_sequencer: RTL and testbench
=======================================

Name: nibble_alu_sequencer

Overview:
- Initiator side of the 4-bit ALU interface (carryIn/mode/func/aPort/bPort in, dataOut/carryOut back).
- Accepts 8-bit instructions (4-bit opcode + 4-bit immediate) over a valid/ready handshake and drives the ALU operand/control ports.
- Captures the ALU result into a 4-bit accumulator, with carry and zero flags.
- Sits between instruction fetch and the ALU in the Nibbler datapath.

Parameters:
- ALU_LAT, 1, clock cycles ALU inputs are held stable before dataOut/carryOut are sampled (1..7).
- FUNC_ADD, 4'b1001, ALU func code for A plus B (mode=0).
- FUNC_SUB, 4'b0110, ALU func code for A minus B (mode=0, carryIn=1 means no borrow).
- FUNC_AND, 4'b1011, ALU func code for A AND B (mode=1).
- FUNC_OR, 4'b1110, ALU func code for A OR B (mode=1).
- FUNC_XOR, 4'b0110, ALU func code for A XOR B (mode=1).
- FUNC_NOT, 4'b0000, ALU func code for NOT A (mode=1).

Ports:
- clk  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- instr_valid  in  1  instruction present.
- instr  in  8  [7:4] opcode, [3:0] immediate.
- instr_ready  out  1  sequencer can accept an instruction.
- aPort  out  4  ALU operand A (always acc).
- bPort  out  4  ALU operand B (latched immediate).
- func  out  4  ALU function select.
- mode  out  1  ALU mode (0 arith, 1 logic).
- carryIn  out  1  ALU carry input.
- dataOut  in  4  ALU result.
- carryOut  in  1  ALU carry output.
- acc  out  4  accumulator.
- carry_flag  out  1  carry flag.
- zero_flag  out  1  1 when acc==0.
- done  out  1  one-cycle pulse when an instruction retires.
- illegal  out  1  one-cycle pulse with done for an undefined opcode.

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE.
  - acc=0, carry_flag=0, zero_flag=1.
  - aPort, bPort, func, mode, carryIn = 0.
  - done=0, illegal=0.
  - instr_ready=0 while reset is high; 1 on the first clk edge after release.
  - Reset mid-instruction aborts it: no writeback, no done.
- States:
  - IDLE: instr_ready=1. On valid&ready at a clk edge, latch opcode/imm and clear instr_ready.
    - ALU ops (ADD, ADC, SUB, SBC, AND, OR, XOR, NOT) -> ISSUE.
    - Local ops -> RETIRE.
  - ISSUE: aPort=acc, bPort=imm, func/mode/carryIn per opcode, all registered and stable for exactly ALU_LAT cycles. A counter runs ALU_LAT-1 down to 0; at 0 -> CAPTURE.
  - CAPTURE: sample dataOut -> acc and carryOut -> carry_flag (arith ops only; logic ops leave carry_flag unchanged); -> RETIRE.
  - RETIRE: done=1 for one cycle; zero_flag reflects new acc; -> IDLE (instr_ready=1 next cycle).
- Opcodes:
  - 0x0 NOP: no change.
  - 0x1 LDI: acc=imm.
  - 0x2 ADD: carryIn=0.
  - 0x3 ADC: carryIn=carry_flag.
  - 0x4 SUB: carryIn=1.
  - 0x5 SBC: carryIn=carry_flag.
  - 0x6 AND, 0x7 OR, 0x8 XOR: carryIn=0.
  - 0x9 NOT: bPort=0.
  - 0xA CLC: carry=0.
  - 0xB SEC: carry=1.
  - 0xC-0xF: no state change; illegal=1 together with done.
- Latency from accept edge to done-high cycle:
  - ALU ops: ALU_LAT+2 cycles.
  - Local ops: 1 cycle.
- Throughput: one instruction in flight. instr_valid while busy is ignored, not queued; the source must hold it until the ready handshake.
- ALU outputs hold their last driven values outside ISSUE; bench samples them only in ISSUE.
- Arithmetic wraps modulo 16. Carry comes solely from the ALU's carryOut.

Test Plan:
- Reset then LDI 0x7 -> done one cycle after accept; acc=7, zero_flag=0, carry_flag=0.
- acc=0xF, ADD imm 0x1, ALU model returns 0x0/carry 1 -> aPort=F, bPort=1, func=FUNC_ADD, mode=0, carryIn=0 held ALU_LAT cycles; acc=0, carry_flag=1, zero_flag=1, done at accept+3 (ALU_LAT=1).
- SEC then ADC imm 0x2 with acc=0x3 -> carryIn=1 driven; acc=6, carry_flag=0.
- acc=0xC, XOR imm 0xA with carry_flag=1 -> mode=1, func=FUNC_XOR; acc=6, carry_flag stays 1.
- Opcode 0xE -> done and illegal pulse together one cycle after accept; acc/flags unchanged. instr_valid held high during an ADD is not accepted until instr_ready returns.
- Assert reset during ISSUE of SUB -> all outputs zero immediately, no done; after release instr_ready=1 and next LDI works. Repeat ADD test with ALU_LAT=3 -> done at accept+5.

Source files
------------

// File: rtl/nibble_alu_sequencer.sv
// rtl/nibble_alu_sequencer.sv - instruction sequencer driving a 4-bit ALU
//
// Accepts 8-bit instructions ({opcode, immediate}) over a valid/ready
// handshake. ALU operations drive the ALU ports and capture the result into a
// 4-bit accumulator. Local operations (NOP, LDI, CLC, SEC, undefined opcodes)
// retire directly.
//
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   instr_valid/instr/instr_ready  instruction handshake ({opcode, imm})
//   aPort, bPort, func, mode, carryIn  registered ALU controls
//   dataOut, carryOut           ALU result
//   acc, carry_flag, zero_flag  architectural state
//   done, illegal               retire pulse, undefined-opcode pulse
module nibble_alu_sequencer #(
  parameter int         ALU_LAT  = 1,
  parameter logic [3:0] FUNC_ADD = 4'b1001,
  parameter logic [3:0] FUNC_SUB = 4'b0110,
  parameter logic [3:0] FUNC_AND = 4'b1011,
  parameter logic [3:0] FUNC_OR  = 4'b1110,
  parameter logic [3:0] FUNC_XOR = 4'b0110,
  parameter logic [3:0] FUNC_NOT = 4'b0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       instr_valid,
  input  logic [7:0] instr,
  output logic       instr_ready,
  output logic [3:0] aPort,
  output logic [3:0] bPort,
  output logic [3:0] func,
  output logic       mode,
  output logic       carryIn,
  input  logic [3:0] dataOut,
  input  logic       carryOut,
  output logic [3:0] acc,
  output logic       carry_flag,
  output logic       zero_flag,
  output logic       done,
  output logic       illegal
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RETIRE  = 2'd3
  } state_t;

  localparam logic [2:0] LAT_LOAD = 3'(ALU_LAT - 1);

  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_ADC = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_SBC = 4'h5;
  localparam logic [3:0] OP_AND = 4'h6;
  localparam logic [3:0] OP_OR  = 4'h7;
  localparam logic [3:0] OP_XOR = 4'h8;
  localparam logic [3:0] OP_NOT = 4'h9;
  localparam logic [3:0] OP_CLC = 4'hA;
  localparam logic [3:0] OP_SEC = 4'hB;

  state_t     state;
  state_t     nextState;
  logic       armed;       // keeps instr_ready low until the first edge after reset
  logic [3:0] opReg;
  logic [2:0] latCnt;

  logic [3:0] newOp;
  logic [3:0] newImm;
  logic       accept;
  logic       newIsAlu;
  logic       opIsArith;

  logic [3:0] decFunc;
  logic       decMode;
  logic       decCin;

  assign newOp     = instr[7:4];
  assign newImm    = instr[3:0];
  assign accept    = instr_valid && instr_ready;
  assign newIsAlu  = (newOp >= OP_ADD) && (newOp <= OP_NOT);
  assign opIsArith = (opReg >= OP_ADD) && (opReg <= OP_SBC);
  assign zero_flag = (acc == 4'd0);

  // ALU control decode for the instruction being accepted
  always_comb begin
    decFunc = 4'd0;
    decMode = 1'b0;
    decCin  = 1'b0;
    case (newOp)
      OP_ADD: decFunc = FUNC_ADD;
      OP_ADC: begin decFunc = FUNC_ADD; decCin = carry_flag; end
      OP_SUB: begin decFunc = FUNC_SUB; decCin = 1'b1; end
      OP_SBC: begin decFunc = FUNC_SUB; decCin = carry_flag; end
      OP_AND: begin decFunc = FUNC_AND; decMode = 1'b1; end
      OP_OR:  begin decFunc = FUNC_OR;  decMode = 1'b1; end
      OP_XOR: begin decFunc = FUNC_XOR; decMode = 1'b1; end
      OP_NOT: begin decFunc = FUNC_NOT; decMode = 1'b1; end
      default: ;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (accept) nextState = newIsAlu ? ISSUE : RETIRE;
      ISSUE:   if (latCnt == 3'd0) nextState = CAPTURE;
      CAPTURE: nextState = RETIRE;
      RETIRE:  nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    instr_ready = (state == IDLE) && armed;
    done        = (state == RETIRE);
    illegal     = (state == RETIRE) && (opReg >= 4'hC);
  end

  // Datapath: ALU port registers, accumulator, carry flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      armed      <= 1'b0;
      opReg      <= 4'd0;
      latCnt     <= 3'd0;
      aPort      <= 4'd0;
      bPort      <= 4'd0;
      func       <= 4'd0;
      mode       <= 1'b0;
      carryIn    <= 1'b0;
      acc        <= 4'd0;
      carry_flag <= 1'b0;
    end else begin
      armed <= 1'b1;
      case (state)
        IDLE: begin
          if (accept) begin
            opReg  <= newOp;
            latCnt <= LAT_LOAD;
            if (newIsAlu) begin
              aPort   <= acc;
              bPort   <= (newOp == OP_NOT) ? 4'd0 : newImm;
              func    <= decFunc;
              mode    <= decMode;
              carryIn <= decCin;
            end
            // Local operations take effect at accept so RETIRE shows the result
            case (newOp)
              OP_LDI:  acc        <= newImm;
              OP_CLC:  carry_flag <= 1'b0;
              OP_SEC:  carry_flag <= 1'b1;
              default: ;
            endcase
          end
        end
        ISSUE: begin
          if (latCnt != 3'd0) latCnt <= latCnt - 3'd1;
        end
        CAPTURE: begin
          acc <= dataOut;
          if (opIsArith) carry_flag <= carryOut;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_alu_sequencer.sv
// tb/tb_nibble_alu_sequencer.sv - self-checking bench for nibble_alu_sequencer
module tb_nibble_alu_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       iv   [2];
  logic [7:0] ins  [2];
  logic       rdy  [2];
  logic [3:0] aP   [2];
  logic [3:0] bP   [2];
  logic [3:0] fn   [2];
  logic       md   [2];
  logic       ci   [2];
  logic [3:0] dO   [2];
  logic       cO   [2];
  logic [3:0] accO [2];
  logic       cf   [2];
  logic       zf   [2];
  logic       dn   [2];
  logic       il   [2];

  // reference state
  logic [3:0] mAcc [2];
  logic       mCf  [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Index 0: ALU_LAT=1, index 1: ALU_LAT=3
  nibble_alu_sequencer #(.ALU_LAT(1)) u1 (
    .clk(clk), .reset(reset), .instr_valid(iv[0]), .instr(ins[0]), .instr_ready(rdy[0]),
    .aPort(aP[0]), .bPort(bP[0]), .func(fn[0]), .mode(md[0]), .carryIn(ci[0]),
    .dataOut(dO[0]), .carryOut(cO[0]), .acc(accO[0]), .carry_flag(cf[0]),
    .zero_flag(zf[0]), .done(dn[0]), .illegal(il[0]));

  nibble_alu_sequencer #(.ALU_LAT(3)) u3 (
    .clk(clk), .reset(reset), .instr_valid(iv[1]), .instr(ins[1]), .instr_ready(rdy[1]),
    .aPort(aP[1]), .bPort(bP[1]), .func(fn[1]), .mode(md[1]), .carryIn(ci[1]),
    .dataOut(dO[1]), .carryOut(cO[1]), .acc(accO[1]), .carry_flag(cf[1]),
    .zero_flag(zf[1]), .done(dn[1]), .illegal(il[1]));

  // ALU behaviour: {carryOut, dataOut}
  function automatic logic [4:0] aluRef(input logic [3:0] a, input logic [3:0] b,
                                        input logic [3:0] f, input logic m, input logic c);
    logic [4:0] r;
    r = 5'h1F;
    if (!m && f == 4'b1001) r = {1'b0, a} + {1'b0, b} + {4'd0, c};
    else if (!m && f == 4'b0110) r = {1'b0, a} + {1'b0, ~b} + {4'd0, c};
    else if (m) begin
      case (f)
        4'b1011: r[3:0] = a & b;
        4'b1110: r[3:0] = a | b;
        4'b0110: r[3:0] = a ^ b;
        4'b0000: r[3:0] = ~a;
        default: r[3:0] = 4'hF;
      endcase
      r[4] = ~(a[1] ^ c);  // carry is meaningless for logic ops
    end
    return r;
  endfunction

  assign {cO[0], dO[0]} = aluRef(aP[0], bP[0], fn[0], md[0], ci[0]);
  assign {cO[1], dO[1]} = aluRef(aP[1], bP[1], fn[1], md[1], ci[1]);

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Run one instruction on DUT w, checking ALU drive, latency and results.
  // holdValid keeps instr_valid asserted until retire.
  task automatic runOne(input int w, input logic [7:0] x, input bit holdValid);
    int         lat, n, waitCnt, a, b, c, s, aluLat;
    bit         seen, isAlu;
    logic [3:0] op, imm, nAcc, f;
    logic       nCf, m, cin;
    logic [13:0] ctl;
    op = x[7:4];
    imm = x[3:0];
    aluLat = (w == 0) ? 1 : 3;
    isAlu = (op >= 4'h2) && (op <= 4'h9);
    a = int'(mAcc[w]);
    b = int'(imm);
    c = int'(mCf[w]);
    nAcc = mAcc[w];
    nCf = mCf[w];
    f = 4'h0; m = 1'b0; cin = 1'b0;
    case (op)
      4'h1: nAcc = imm;
      4'h2: begin s = a + b;     nAcc = 4'(s); nCf = (s > 15); f = 4'b1001; end
      4'h3: begin s = a + b + c; nAcc = 4'(s); nCf = (s > 15); f = 4'b1001; cin = mCf[w]; end
      4'h4: begin s = a - b;     nAcc = 4'(s); nCf = (s >= 0); f = 4'b0110; cin = 1'b1; end
      4'h5: begin s = a - b - (1 - c); nAcc = 4'(s); nCf = (s >= 0); f = 4'b0110; cin = mCf[w]; end
      4'h6: begin nAcc = mAcc[w] & imm; f = 4'b1011; m = 1'b1; end
      4'h7: begin nAcc = mAcc[w] | imm; f = 4'b1110; m = 1'b1; end
      4'h8: begin nAcc = mAcc[w] ^ imm; f = 4'b0110; m = 1'b1; end
      4'h9: begin nAcc = ~mAcc[w];      f = 4'b0000; m = 1'b1; end
      4'hA: nCf = 1'b0;
      4'hB: nCf = 1'b1;
      default: ;
    endcase
    ctl = {mAcc[w], (op == 4'h9) ? 4'h0 : imm, f, m, cin};
    lat = isAlu ? aluLat + 2 : 1;

    @(negedge clk);
    waitCnt = 0;
    while (!rdy[w] && waitCnt < 40) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!rdy[w]) begin
      checkVal("readyTimeout", 32'd0, 32'd1);
      return;
    end
    ins[w] = x;
    iv[w] = 1'b1;

    seen = 0;
    n = 0;
    for (int k = 1; k <= lat + 3 && !seen; k++) begin
      @(negedge clk);
      if (k == 1 && !holdValid) iv[w] = 1'b0;
      if (isAlu && k <= aluLat)
        checkVal("issueCtl", {aP[w], bP[w], fn[w], md[w], ci[w]}, 32'(ctl));
      if (dn[w]) begin
        seen = 1;
        n = k;
      end
    end
    iv[w] = 1'b0;
    checkVal("latency", 32'(n), 32'(lat));
    if (seen) begin
      checkVal("acc", 32'(accO[w]), 32'(nAcc));
      checkVal("flags", {29'd0, cf[w], zf[w], il[w]}, {29'd0, nCf, nAcc == 4'd0, op >= 4'hC});
      checkVal("busyReady", 32'(rdy[w]), 32'd0);
      @(negedge clk);
      checkVal("donePulse", {dn[w], rdy[w]}, 32'b01);
    end
    mAcc[w] = nAcc;
    mCf[w] = nCf;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      iv[i] = 1'b0;
      ins[i] = 8'h00;
      mAcc[i] = 4'd0;
      mCf[i] = 1'b0;
    end
    reset = 1'b1;
    #1;
    for (int i = 0; i < 2; i++)
      checkVal("resetOuts", {rdy[i], aP[i], bP[i], fn[i], md[i], ci[i], accO[i], cf[i], zf[i], dn[i], il[i]},
               32'b0_0000_0000_0000_0_0_0000_0_1_0_0);
    repeat (3) @(negedge clk);
    checkVal("readyInReset", {rdy[0], rdy[1]}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    checkVal("readyAfterReset", {rdy[0], rdy[1]}, 32'b11);

    // Directed sequences on both latencies
    for (int w = 0; w < 2; w++) begin
      runOne(w, 8'h17, 0);   // LDI 7
      runOne(w, 8'h1F, 0);   // LDI F
      runOne(w, 8'h21, 0);   // ADD 1 -> 0, carry
      runOne(w, 8'h13, 0);   // LDI 3
      runOne(w, 8'hB0, 0);   // SEC
      runOne(w, 8'h32, 0);   // ADC 2 -> 6
      runOne(w, 8'h1C, 0);   // LDI C
      runOne(w, 8'hB0, 0);   // SEC
      runOne(w, 8'h8A, 0);   // XOR A -> 6, carry kept
      runOne(w, 8'hE5, 0);   // illegal
      runOne(w, 8'h25, 1);   // ADD with valid held through busy
      runOne(w, 8'h40, 0);   // SUB 0
      runOne(w, 8'h90, 0);   // NOT
      runOne(w, 8'hA0, 0);   // CLC
      runOne(w, 8'h5F, 0);   // SBC F
    end

    // Reset during ISSUE of a SUB on the ALU_LAT=3 instance
    @(negedge clk);
    ins[1] = 8'h43;
    iv[1] = 1'b1;
    @(negedge clk);
    iv[1] = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    for (int i = 0; i < 2; i++)
      checkVal("midReset", {rdy[i], aP[i], bP[i], fn[i], md[i], ci[i], accO[i], cf[i], zf[i], dn[i], il[i]},
               32'b0_0000_0000_0000_0_0_0000_0_1_0_0);
    for (int i = 0; i < 2; i++) begin
      mAcc[i] = 4'd0;
      mCf[i] = 1'b0;
    end
    repeat (4) begin
      @(negedge clk);
      checkVal("noDoneInReset", {dn[0], dn[1]}, 32'd0);
    end
    reset = 1'b0;
    @(negedge clk);
    checkVal("readyAfterMidReset", {rdy[0], rdy[1]}, 32'b11);
    runOne(1, 8'h19, 0);
    runOne(0, 8'h12, 0);

    // Randomized instruction streams
    for (int w = 0; w < 2; w++)
      for (int i = 0; i < 150; i++)
        runOne(w, 8'($urandom), bit'($urandom_range(0, 1)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
